// File: rtl/muldiv_seq_pkg.sv
// Shared RV32 types for the EXE-stage multiply/divide sequencer: ALU op codes,
// sequencer states and op-class predicate masks indexed by the alu_t code.
package riscv_types;

  localparam int XLEN = 32;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_AND    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_XOR    = 5'd4,
    ALU_SLL    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_SLT    = 5'd8,
    ALU_SLTU   = 5'd9,
    ALU_MUL    = 5'd16,
    ALU_MULH   = 5'd17,
    ALU_MULHSU = 5'd18,
    ALU_MULHU  = 5'd19,
    ALU_DIV    = 5'd20,
    ALU_DIVU   = 5'd21,
    ALU_REM    = 5'd22,
    ALU_REMU   = 5'd23
  } alu_t;

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} muldiv_state_t;

  // Bit n set means alu_t value n belongs to the class.
  localparam logic [31:0] M_OP_MASK     = 32'h00FF_0000;
  localparam logic [31:0] DIV_OP_MASK   = 32'h00F0_0000;
  localparam logic [31:0] REM_OP_MASK   = 32'h00C0_0000;
  localparam logic [31:0] A_SIGNED_MASK = 32'h0057_0000;
  localparam logic [31:0] B_SIGNED_MASK = 32'h0053_0000;

  function automatic logic is_m_op(alu_t op);
    return M_OP_MASK[op];
  endfunction

endpackage

// File: rtl/muldiv_seq_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step
// on the {hi, lo} accumulator.
module muldiv_step
  import riscv_types::*;
(
  input  logic              div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   m_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] trial;

  assign sum    = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, m_i} : '0);
  assign rem_sh = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
  assign trial  = rem_sh - {1'b0, m_i};

  always_comb begin
    acc_o = {sum, acc_i[XLEN-1:1]};
    if (div_i) begin
      // Borrow out of the trial subtract means the divisor did not fit.
      if (trial[XLEN]) acc_o = {rem_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
      else             acc_o = {trial[XLEN-1:0],  acc_i[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/n_bit_reg_wclr.sv
// Enabled register with synchronous clear; clear wins over enable.
module n_bit_reg_wclr #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   q_o <= '0;
    else if (clr_i) q_o <= '0;
    else if (en_i)  q_o <= d_i;
  end

endmodule

// File: rtl/muldiv_seq.sv
// RV32M multi-cycle multiply/divide sequencer. MULDIV_FAST_MUL_EN selects a
// single-cycle multiplier in PREP; divides always iterate.
//   state | meaning
//   IDLE  | waiting for an M-op start
//   PREP  | magnitudes/signs, special divides, fast multiply
//   CALC  | XLEN radix-2 iterations
//   FIX   | sign correction, half select
//   DONE  | valid_o pulse
module muldiv_seq
  import riscv_types::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start_i,
  input  logic            flush_i,
  input  alu_t            op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  muldiv_state_t     state_q;
  alu_t              op_q;
  logic              neg_q, rneg_q, valid_q;
  logic [2*XLEN-1:0] acc_q, acc_d, step_acc, prod_fix;
  logic [XLEN-1:0]   m_q, m_d, res_q, res_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              acc_en, m_en, cnt_en, res_en;
  logic              start_ok, op_div, op_rem, a_neg, b_neg;
  logic              div_zero, div_ovf, special, fast_hit;
  logic [XLEN-1:0]   a_raw, b_raw, a_mag, b_mag;
  logic [XLEN-1:0]   special_res, fix_res, quo_fix, rem_fix, fast_res;

  assign start_ok = start_i & is_m_op(op_i);
  assign op_div   = DIV_OP_MASK[op_q];
  assign op_rem   = REM_OP_MASK[op_q];

  // Raw operands sit in acc/m for the PREP cycle only.
  assign a_raw = acc_q[XLEN-1:0];
  assign b_raw = m_q;
  assign a_neg = A_SIGNED_MASK[op_q] & a_raw[XLEN-1];
  assign b_neg = B_SIGNED_MASK[op_q] & b_raw[XLEN-1];
  assign a_mag = a_neg ? -a_raw : a_raw;
  assign b_mag = b_neg ? -b_raw : b_raw;

  assign div_zero = op_div & (b_raw == '0);
  assign div_ovf  = op_div & B_SIGNED_MASK[op_q] & (a_raw == {1'b1, {(XLEN-1){1'b0}}})
                    & (b_raw == '1);
  assign special  = div_zero | div_ovf;
  assign special_res = op_rem ? (div_zero ? a_raw : '0)
                              : (div_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}});

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix  = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
  assign fix_res  = op_div ? (op_rem ? rem_fix : quo_fix)
                           : ((op_q == ALU_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  // Low 2*XLEN bits of the sign-extended product equal the signed product.
  assign fast_prod = {{XLEN{a_neg}}, a_raw} * {{XLEN{b_neg}}, b_raw};
  assign fast_hit  = ~op_div;
  assign fast_res  = (op_q == ALU_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`else
  assign fast_hit = 1'b0;
  assign fast_res = '0;
`endif

  muldiv_step u_step (
    .div_i (op_div),
    .acc_i (acc_q),
    .m_i   (m_q),
    .acc_o (step_acc)
  );

  always_comb begin
    acc_en = 1'b0;  acc_d = acc_q;
    m_en   = 1'b0;  m_d   = m_q;
    cnt_en = 1'b0;  cnt_d = cnt_q;
    res_en = 1'b0;  res_d = res_q;
    case (state_q)
      IDLE: if (start_ok) begin
        acc_en = 1'b1;  acc_d = {{XLEN{1'b0}}, a_i};
        m_en   = 1'b1;  m_d   = b_i;
      end
      PREP: begin
        acc_en = 1'b1;  acc_d = {{XLEN{1'b0}}, a_mag};
        m_en   = 1'b1;  m_d   = b_mag;
        cnt_en = 1'b1;  cnt_d = 5'(XLEN-1);
        if (special) begin
          res_en = 1'b1;  res_d = special_res;
        end else if (fast_hit) begin
          res_en = 1'b1;  res_d = fast_res;
        end
      end
      CALC: begin
        acc_en = 1'b1;  acc_d = step_acc;
        cnt_en = 1'b1;  cnt_d = cnt_q - 5'd1;
      end
      FIX: begin
        res_en = 1'b1;  res_d = fix_res;
      end
      default: ;
    endcase
    res_en = res_en & ~flush_i;
  end

  n_bit_reg_wclr #(.N(2*XLEN)) u_acc (.clk(clk), .reset_n(reset_n), .clr_i(flush_i),
                                      .en_i(acc_en), .d_i(acc_d), .q_o(acc_q));
  n_bit_reg_wclr #(.N(XLEN)) u_m (.clk(clk), .reset_n(reset_n), .clr_i(flush_i),
                                  .en_i(m_en), .d_i(m_d), .q_o(m_q));
  n_bit_reg_wclr #(.N(5)) u_cnt (.clk(clk), .reset_n(reset_n), .clr_i(flush_i),
                                 .en_i(cnt_en), .d_i(cnt_d), .q_o(cnt_q));
  // The result must survive a flush, so its clear is never asserted.
  n_bit_reg_wclr #(.N(XLEN)) u_res (.clk(clk), .reset_n(reset_n), .clr_i(1'b0),
                                    .en_i(res_en), .d_i(res_d), .q_o(res_q));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= ALU_ADD;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (flush_i) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: if (start_ok) begin
            state_q <= PREP;
            op_q    <= op_i;
          end
          PREP: begin
            neg_q  <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            if (special || fast_hit) begin
              state_q <= DONE;
              valid_q <= 1'b1;
            end else begin
              state_q <= CALC;
            end
          end
          CALC: if (cnt_q == 5'd0) state_q <= FIX;
          FIX: begin
            state_q <= DONE;
            valid_q <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign valid_o  = valid_q;
  assign result_o = res_q;
  assign stall_o  = ~flush_i & (((state_q == IDLE) & start_ok) | (busy_o & (state_q != DONE)));

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed table, flush/reset/non-M-op
// sequences and random M-ops checked against a plain-arithmetic model.
module tb_muldiv_seq;
  import riscv_types::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_i = 1'b0;
  logic        flush_i = 1'b0;
  alu_t        op_i = ALU_ADD;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        stall_o, busy_o, valid_o;
  logic [31:0] result_o;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_res = '0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 35;
`endif
  localparam int DIV_LAT = 35;
  localparam int SPC_LAT = 2;

  typedef struct {
    alu_t        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  muldiv_seq dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start_i  (start_i),
    .flush_i  (flush_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .stall_o  (stall_o),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(alu_t op, logic [31:0] a, logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    r  = '0;
    case (op)
      ALU_MUL:    begin p = 64'(sa * sb); r = p[31:0];  end
      ALU_MULH:   begin p = 64'(sa * sb); r = p[63:32]; end
      ALU_MULHSU: begin p = 64'(sa * ub); r = p[63:32]; end
      ALU_MULHU:  begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      ALU_DIV:    if (b == 0) r = '1; else begin p = 64'(sa / sb); r = p[31:0]; end
      ALU_DIVU:   if (b == 0) r = '1; else begin p = 64'(ua / ub); r = p[31:0]; end
      ALU_REM:    if (b == 0) r = a;  else begin p = 64'(sa % sb); r = p[31:0]; end
      ALU_REMU:   if (b == 0) r = a;  else begin p = 64'(ua % ub); r = p[31:0]; end
      default:    r = '0;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(alu_t op, logic [31:0] a, logic [31:0] b);
    bit is_div, is_sdiv;
    is_div  = (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    is_sdiv = (op == ALU_DIV) || (op == ALU_REM);
    if (!is_div) return MUL_LAT;
    if (b == 0 || (is_sdiv && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return SPC_LAT;
    return DIV_LAT;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op in the current cycle and follow it to its valid pulse.
  task automatic run_op(input alu_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input string tag);
    int lat;
    bit seen, bad;
    seen = 0; bad = 0; lat = 1;
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    #1 chk({tag, "/stall_T"}, 32'(stall_o), 32'd1);
    tick();
    start_i = 1'b0; a_i = $urandom; b_i = $urandom;
    while (!seen && lat <= 45) begin
      #1;
      if (valid_o) seen = 1;
      else begin
        if (stall_o !== 1'b1 || busy_o !== 1'b1) bad = 1;
        start_i = 1'($urandom_range(0, 1));
        op_i = ALU_MUL;
        tick();
        lat++;
      end
    end
    start_i = 1'b0;
    chk({tag, "/valid_seen"}, 32'(seen), 32'd1);
    chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "/result"}, result_o, exp);
    chk({tag, "/stall_busy"}, 32'(bad), 32'd0);
    chk({tag, "/stall_done"}, 32'(stall_o), 32'd0);
    tick();
    #1;
    chk({tag, "/valid_pulse"}, {30'b0, valid_o, busy_o}, 32'd0);
    chk({tag, "/result_hold"}, result_o, exp);
    last_res = exp;
  endtask

  initial begin
    vec_t v;
    bit   bad;

    vecs.push_back('{ALU_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT});
    vecs.push_back('{ALU_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, DIV_LAT});
    vecs.push_back('{ALU_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, DIV_LAT});
    vecs.push_back('{ALU_DIVU,   32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, SPC_LAT});
    vecs.push_back('{ALU_REMU,   32'h0000_0005, 32'h0000_0000, 32'h0000_0005, SPC_LAT});
    vecs.push_back('{ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPC_LAT});
    vecs.push_back('{ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPC_LAT});
    vecs.push_back('{ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT});
    vecs.push_back('{ALU_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, MUL_LAT});
    vecs.push_back('{ALU_MUL,    32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB, MUL_LAT});
    vecs.push_back('{ALU_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT});
    vecs.push_back('{ALU_REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, DIV_LAT});
    vecs.push_back('{ALU_DIV,    32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFF, SPC_LAT});
    vecs.push_back('{ALU_REM,    32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, SPC_LAT});
    vecs.push_back('{ALU_DIVU,   32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, DIV_LAT});

    #1;
    chk("reset/outputs", {29'b0, stall_o, busy_o, valid_o}, 32'd0);
    chk("reset/result", result_o, 32'd0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      v = vecs[i];
      run_op(v.op, v.a, v.b, v.res, v.lat, $sformatf("vec%0d", i));
    end

    // Non-M ops must be ignored entirely.
    for (int k = 0; k < 3; k++) begin
      start_i = 1'b1;
      op_i = (k == 0) ? ALU_ADD : (k == 1) ? ALU_SLTU : alu_t'(5'd31);
      a_i = 32'd3; b_i = 32'd7;
      #1 chk($sformatf("nonm%0d/stall", k), 32'(stall_o), 32'd0);
      tick();
      start_i = 1'b0;
      #1 chk($sformatf("nonm%0d/busy_valid", k), {30'b0, busy_o, valid_o}, 32'd0);
    end
    tick();

    // Start together with flush is dropped.
    start_i = 1'b1; flush_i = 1'b1; op_i = ALU_MUL;
    #1 chk("startflush/stall", 32'(stall_o), 32'd0);
    tick();
    start_i = 1'b0; flush_i = 1'b0;
    #1 chk("startflush/busy", 32'(busy_o), 32'd0);
    tick();

    // MULHU flushed at T+10, then MUL 3x7 started at T+11.
    bad = 0;
    start_i = 1'b1; op_i = ALU_MULHU; a_i = 32'hFFFF_FFFF; b_i = 32'hFFFF_FFFF;
    #1 chk("flush/stall_T", 32'(stall_o), 32'd1);
    for (int k = 1; k < 10; k++) begin
      tick();
      start_i = 1'b0;
      #1 if (valid_o) bad = 1;
    end
    tick();
    flush_i = 1'b1;
    #1;
    chk("flush/stall_T10", 32'(stall_o), 32'd0);
    chk("flush/no_valid", {31'b0, valid_o | bad}, 32'd0);
    tick();
    flush_i = 1'b0;
    #1;
    chk("flush/busy_T11", 32'(busy_o), 32'd0);
    chk("flush/result_kept", result_o, last_res);
    run_op(ALU_MUL, 32'd3, 32'd7, 32'd21, MUL_LAT, "post_flush");

    for (int k = 0; k < 24; k++) begin
      alu_t        op;
      logic [31:0] a, b;
      op = alu_t'(5'(16 + $urandom_range(0, 7)));
      a = pick();
      b = pick();
      run_op(op, a, b, ref_res(op, a, b), ref_lat(op, a, b), $sformatf("rnd%0d", k));
    end

    // Asynchronous reset in the middle of a divide.
    start_i = 1'b1; op_i = ALU_DIVU; a_i = 32'd100; b_i = 32'd7;
    tick();
    start_i = 1'b0;
    repeat (5) tick();
    #1 reset_n = 1'b0;
    #1;
    chk("midreset/outputs", {29'b0, stall_o, busy_o, valid_o}, 32'd0);
    chk("midreset/result", result_o, 32'd0);
    #2 reset_n = 1'b1;
    tick();
    run_op(ALU_DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
